regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_pkg.sv | 22 ++
 rtl/regfile_dump_reader_if.sv | 28 ++
 rtl/word_to_byte_serializer.sv | 53 +++++
 rtl/regfile_dump_reader.sv | 117 +++++++++++
 tb/tb_regfile_dump_reader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file debug dump reader.
// Holds the FSM state encoding, byte width and words-to-bytes ratio.
package regfile_dump_pkg;

    localparam int NB_BYTE        = 8;
    localparam int NB_DATA_DEF    = 32;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3,
        CSUM = 3'd4
    } state_t;

    // Width of a counter/index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file debug read port plus the valid/ready byte stream to the UART TX.
// master = dump reader, slave = register file / UART side.
interface regfile_dump_reader_if #(
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = regfile_dump_pkg::NB_BYTE
);
    import regfile_dump_pkg::*;

    localparam int _NB_ADDR = clog2_min1(N_REGS);

    logic [_NB_ADDR-1:0] o_read_addr_debug;
    logic [NB_DATA-1:0]  i_data_debug;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                o_tx_valid;
    logic                i_tx_ready;

    modport master (
        output o_read_addr_debug, o_tx_data, o_tx_valid,
        input  i_data_debug, i_tx_ready
    );

    modport slave (
        input  o_read_addr_debug, o_tx_data, o_tx_valid,
        output i_data_debug, i_tx_ready
    );

endinterface

// File: rtl/word_to_byte_serializer.sv
// Purpose: latch a word on i_load and emit it MSB-byte-first on a valid/ready stream.
// Latency: first byte valid the cycle after i_load; following bytes back-to-back.
// Backpressure: byte and position hold while o_valid=1 and i_ready=0.
module word_to_byte_serializer
    import regfile_dump_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = regfile_dump_pkg::NB_BYTE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_accept
);

    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = clog2_min1(BPW);

    logic [NB_DATA-1:0] shreg;
    logic [NB_CNT-1:0]  byte_cnt;
    logic               vld;

    assign o_byte   = shreg[NB_DATA-1 -: NB_BYTE];
    assign o_valid  = vld;
    assign o_last   = (byte_cnt == NB_CNT'(BPW - 1));
    assign o_accept = vld & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
            vld      <= 1'b0;
        end else if (i_load) begin
            shreg    <= i_word;
            byte_cnt <= '0;
            vld      <= 1'b1;
        end else if (o_accept) begin
            shreg <= shreg << NB_BYTE;
            if (o_last) begin
                byte_cnt <= '0;
                vld      <= 1'b0;
            end else begin
                byte_cnt <= byte_cnt + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Purpose: on i_start walk registers 0..N_REGS-1 and stream each word MSB-byte-first.
// Latency: i_start at edge k gives first o_tx_valid at k+2; one idle cycle between words.
// Backpressure: i_tx_ready=0 freezes byte, address and state. Option: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = regfile_dump_pkg::NB_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    regfile_dump_reader_if.master bus,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int                  _NB_ADDR  = clog2_min1(N_REGS);
    localparam logic [_NB_ADDR-1:0] LAST_ADDR = _NB_ADDR'(N_REGS - 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t              state, state_nxt;
    logic [_NB_ADDR-1:0] addr;
    logic                ser_load;
    logic [NB_BYTE-1:0]  ser_byte;
    logic                ser_vld;
    logic                ser_last;
    logic                ser_accept;
    logic                word_end;

    word_to_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (ser_load),
        .i_word   (bus.i_data_debug),
        .o_byte   (ser_byte),
        .o_valid  (ser_vld),
        .i_ready  (bus.i_tx_ready),
        .o_last   (ser_last),
        .o_accept (ser_accept)
    );

    assign word_end              = (state == SEND) && ser_accept && ser_last;
    assign bus.o_read_addr_debug = addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (word_end) state_nxt = (addr == LAST_ADDR) ? AFTER_DATA : LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM: if (bus.i_tx_ready) state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address only advances on the last byte of a word, so it never passes LAST_ADDR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr <= '0;
        end else if ((state == IDLE && i_start) || state == DONE) begin
            addr <= '0;
        end else if (word_end && addr != LAST_ADDR) begin
            addr <= addr + _NB_ADDR'(1);
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csum <= '0;
        end else if (state == IDLE && i_start) begin
            csum <= '0;
        end else if (state == SEND && ser_accept) begin
            csum <= csum ^ ser_byte;
        end
    end

    always_comb begin
        ser_load       = (state == LOAD);
        o_busy         = (state == LOAD) || (state == SEND) || (state == CSUM);
        o_done         = (state == DONE);
        bus.o_tx_valid = ser_vld || (state == CSUM);
        bus.o_tx_data  = (state == CSUM) ? csum : ser_byte;
    end
`else
    always_comb begin
        ser_load       = (state == LOAD);
        o_busy         = (state == LOAD) || (state == SEND);
        o_done         = (state == DONE);
        bus.o_tx_valid = ser_vld;
        bus.o_tx_data  = ser_byte;
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump scenarios against a byte-list model,
// plus reset-mid-dump and start-held sequences.
module tb_regfile_dump_reader;

    localparam int NB_DATA = 32;
    localparam int N_REGS  = 32;
    localparam int NB_BYTE = 8;
    localparam int BPW     = NB_DATA / NB_BYTE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int         EXP_N     = N_REGS * BPW + 1;
    localparam logic [7:0] LAST_PLAIN = 8'h00;
    localparam logic [7:0] LAST_PATCH = 8'h09;
`else
    localparam int         EXP_N     = N_REGS * BPW;
    localparam logic [7:0] LAST_PLAIN = 8'h1F;
    localparam logic [7:0] LAST_PATCH = 8'h1F;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic [NB_DATA-1:0] regs [N_REGS];
    logic [7:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_dump_reader_if #(.NB_DATA(NB_DATA), .N_REGS(N_REGS), .NB_BYTE(NB_BYTE)) bus ();

    assign bus.i_data_debug = regs[bus.o_read_addr_debug];

    regfile_dump_reader #(.NB_DATA(NB_DATA), .N_REGS(N_REGS), .NB_BYTE(NB_BYTE)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .bus    (bus),
        .o_busy (busy),
        .o_done (done)
    );

    typedef struct {
        int          mode;     // 0: ready always, 1: random ready, 2: 20-cycle stall on first byte
        bit          hold;     // keep i_start high until o_done
        logic [31:0] reg1;
        int          exp_n;
        logic [7:0]  exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream: every register, most significant byte first, then the XOR byte if enabled.
    task automatic build_model();
        logic [7:0] x;
        logic [7:0] v;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < N_REGS; r++) begin
            for (int b = BPW - 1; b >= 0; b--) begin
                v = regs[r][b*8 +: 8];
                exp_q.push_back(v);
                x = x ^ v;
            end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_dump(input int mode, input bit hold, input int exp_n, input logic [7:0] exp_last);
        int         got;
        int         stall;
        bit         seen_done;
        logic       r;
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        logic [4:0] pa;
        logic [7:0] last_b;
        got = 0; stall = 0; seen_done = 1'b0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; pa = 5'd0; last_b = 8'h00;
        build_model();
        @(negedge clk);
        start = 1'b1;
        bus.i_tx_ready = (mode == 0);
        @(negedge clk);
        chk("lat_load_valid", 32'(bus.o_tx_valid), 32'd0);
        chk("lat_load_busy", 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        @(negedge clk);
        chk("lat_first_valid", 32'(bus.o_tx_valid), 32'd1);
        for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
                start = 1'b0;
                chk("busy_with_done", 32'(busy), 32'd0);
                chk("byte_count", 32'(got), 32'(exp_n));
                chk("last_byte", 32'(last_b), 32'(exp_last));
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                    chk("hold_data", 32'(bus.o_tx_data), 32'(pd));
                    chk("hold_addr", 32'(bus.o_read_addr_debug), 32'(pa));
                end
                if (mode == 2 && bus.o_tx_valid && stall < 20) begin
                    stall++;
                    r = 1'b0;
                    if (stall == 20) begin
                        chk("stall_valid", 32'(bus.o_tx_valid), 32'd1);
                        chk("stall_data", 32'(bus.o_tx_data), 32'h00);
                        chk("stall_addr", 32'(bus.o_read_addr_debug), 32'd0);
                    end
                end else if (mode == 1) begin
                    r = 1'($urandom_range(0, 1));
                end else begin
                    r = 1'b1;
                end
                bus.i_tx_ready = r;
                if (bus.o_tx_valid && r) begin
                    if (got < exp_q.size())
                        chk($sformatf("byte%0d", got), 32'(bus.o_tx_data), 32'(exp_q[got]));
                    else
                        chk("byte_overrun", 32'(got + 1), 32'(exp_q.size()));
                    last_b = bus.o_tx_data;
                    got++;
                end
                pv = bus.o_tx_valid; pr = r; pd = bus.o_tx_data; pa = bus.o_read_addr_debug;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        bus.i_tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("idle_no_valid", 32'(bus.o_tx_valid), 32'd0);
            chk("idle_not_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_dump();
        int got;
        bit hit;
        got = 0; hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bus.i_tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
            @(negedge clk);
            if (bus.o_tx_valid) begin
                if (got == 50) begin
                    hit = 1'b1;
                    rst = 1'b1;
                end else begin
                    got++;
                end
            end
        end
        chk("reset_point_reached", 32'(hit), 32'd1);
        @(negedge clk);
        chk("rst_mid_valid", 32'(bus.o_tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", 32'(bus.o_read_addr_debug), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        vecs[0] = '{mode: 0, hold: 1'b0, reg1: 32'h1,        exp_n: EXP_N, exp_last: LAST_PLAIN};
        vecs[1] = '{mode: 1, hold: 1'b0, reg1: 32'h1,        exp_n: EXP_N, exp_last: LAST_PLAIN};
        vecs[2] = '{mode: 0, hold: 1'b1, reg1: 32'h1,        exp_n: EXP_N, exp_last: LAST_PLAIN};
        vecs[3] = '{mode: 2, hold: 1'b0, reg1: 32'h1,        exp_n: EXP_N, exp_last: LAST_PLAIN};
        vecs[4] = '{mode: 1, hold: 1'b0, reg1: 32'h12345678, exp_n: EXP_N, exp_last: LAST_PATCH};

        for (int r = 0; r < N_REGS; r++) regs[r] = 32'(r);
        rst = 1'b1;
        start = 1'b0;
        bus.i_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.o_tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(bus.o_read_addr_debug), 32'd0);
        chk("rst_data", 32'(bus.o_tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            regs[1] = vecs[i].reg1;
            run_dump(vecs[i].mode, vecs[i].hold, vecs[i].exp_n, vecs[i].exp_last);
        end

        regs[1] = 32'h1;
        reset_mid_dump();
        run_dump(0, 1'b0, EXP_N, LAST_PLAIN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
